// File: rtl/wash_tick_gen.sv
// rtl/wash_tick_gen.sv - second strobe and modulo carry tick source with stretched level pulses
// WASH_TICK_FAST_SIM_EN: forces divider to 10 and clamps pulse width to 9 for short simulations.
module wash_tick_gen #(
  parameter int CLK_DIV = 100000000,
  parameter int SUB_MAX = 59,
  parameter int PULSE_W = 4
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       run,
  input  logic       pause,
  output logic       sec_pulse,
  output logic       carry_pulse,
  output logic [5:0] sub_count,
  output logic       busy
);

`ifdef WASH_TICK_FAST_SIM_EN
  localparam int DIV_EFF = 10;
  localparam int PW_EFF  = (PULSE_W > 9) ? 9 : PULSE_W;
`else
  localparam int DIV_EFF = CLK_DIV;
  localparam int PW_EFF  = PULSE_W;
`endif

  localparam logic [26:0] PRE_LAST = 27'(DIV_EFF - 1);
  localparam logic [26:0] PW_LOAD  = 27'(PW_EFF);
  localparam logic [5:0]  SUB_LAST = 6'(SUB_MAX);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  mode;
  logic [26:0] presc;
  logic        wrap_q;
  logic [26:0] sec_cnt;
  logic [26:0] carry_cnt;

  always_comb begin
    mode = ST_IDLE;
    if (run) mode = pause ? ST_HOLD : ST_RUN;
  end

  // A wrap is registered first and consumed on the next edge even if that edge is
  // in HOLD, so pausing right after a wrap never loses the tick.
  always_ff @(posedge CLK100MHZ) begin
    if (rst || mode == ST_IDLE) begin
      presc     <= '0;
      wrap_q    <= 1'b0;
      sub_count <= '0;
      sec_cnt   <= '0;
      carry_cnt <= '0;
    end else begin
      wrap_q <= (mode == ST_RUN) && (presc == PRE_LAST);
      if (mode == ST_RUN) begin
        presc <= (presc == PRE_LAST) ? 27'd0 : presc + 27'd1;
      end

      if (wrap_q) begin
        sub_count <= (sub_count == SUB_LAST) ? 6'd0 : sub_count + 6'd1;
      end

      if (wrap_q) begin
        sec_cnt <= PW_LOAD;
      end else if (sec_cnt != 27'd0) begin
        sec_cnt <= sec_cnt - 27'd1;
      end

      if (wrap_q && sub_count == SUB_LAST) begin
        carry_cnt <= PW_LOAD;
      end else if (carry_cnt != 27'd0) begin
        carry_cnt <= carry_cnt - 27'd1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (mode == ST_RUN);
    end
  end

  assign sec_pulse   = (sec_cnt != 27'd0);
  assign carry_pulse = (carry_cnt != 27'd0);

endmodule
